// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-addressed memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit over a word-wide memory bus, read-modify-write for sub-word stores.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemDataSize,
    input  logic        MemDataSign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    mem_access_unit_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
    logic [1:0]  state, sz, off;
    logic        ld, sgn, bad;
    logic [15:0] wd;
    logic [29:0] maddr;
    logic [31:0] mwdata, ld_val, merged;
    logic [7:0]  b;
    logic [15:0] h;
    assign bad = (MemRead == MemWrite) || (MemDataSize == 2'b00) ||
                 (MemDataSize == 2'b10 && addr[0]) || (MemDataSize == 2'b11 && addr[1:0] != 2'b00);
    always_comb begin
        b      = bus.mem_rdata[{off, 3'b000} +: 8];
        h      = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_val = sz == 2'b11 ? bus.mem_rdata :
                 sz == 2'b10 ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
        merged = sz == 2'b10 ? (off[1] ? {wd, bus.mem_rdata[15:0]} : {bus.mem_rdata[31:16], wd}) :
                 (bus.mem_rdata & ~(32'h0000_00ff << {off, 3'b000})) | ({24'd0, wd[7:0]} << {off, 3'b000});
    end
    // Sub-word stores read the word first, then write back the merged lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rdata  <= '0;
            err    <= 1'b0;
            maddr  <= '0;
            mwdata <= '0;
            ld     <= 1'b0;
            sz     <= '0;
            sgn    <= 1'b0;
            off    <= '0;
            wd     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    ld     <= MemRead;
                    sz     <= MemDataSize;
                    sgn    <= MemDataSign;
                    off    <= addr[1:0];
                    wd     <= wdata[15:0];
                    maddr  <= addr[31:2];
                    mwdata <= wdata;
                    err    <= bad;
                    if (bad) rdata <= '0;
                    state  <= bad ? DONE : (MemWrite && MemDataSize == 2'b11) ? WRITE : READ;
                end
                READ: if (bus.mem_ack) begin
                    if (ld) begin
                        rdata <= ld_val;
                        state <= DONE;
                    end else begin
                        mwdata <= merged;
                        state  <= WRITE;
                    end
                end
                WRITE: if (bus.mem_ack) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    assign ready         = state == IDLE;
    assign done          = state == DONE;
    assign bus.mem_req   = state == READ || state == WRITE;
    assign bus.mem_we    = state == WRITE;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenario tests for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, MemDataSign = 1'b0;
    logic [1:0]  MemDataSize = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, done, err;
    logic [31:0] rdata;
    int          errors = 0, checks = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemDataSize(MemDataSize), .MemDataSign(MemDataSign), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic w, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; MemRead = r; MemWrite = w; MemDataSize = s; MemDataSign = sg; addr = a; wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if ({ready, done, err} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b want 100", {ready, done, err}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h want all 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_load_byte();
        set_req(1, 0, 2'b01, 1, 32'h103, 0);
        bus.mem_rdata = 32'h80FF_0000; bus.mem_ack = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 30'h40}) begin errors++;
            $display("FAIL lb_bus: got req=%b we=%b addr=%h want 1 0 40", bus.mem_req, bus.mem_we, bus.mem_addr); end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL lb_done: got done=%b err=%b want 1 0", done, err); end
        checks++; if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", rdata); end
        tick();
        checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL lb_idle: got ready=%b done=%b want 1 0", ready, done); end
    endtask

    task automatic test_load_half();
        for (int i = 0; i < 2; i++) begin
            set_req(1, 0, 2'b10, i[0], 32'h102, 0);
            bus.mem_rdata = 32'h8001_1234; bus.mem_ack = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            bus.mem_ack = 1'b0;
            checks++; if (rdata !== (i == 0 ? 32'h0000_8001 : 32'hFFFF_8001) || done !== 1'b1) begin errors++;
                $display("FAIL lh_%0d: got rdata=%h done=%b want %h 1", i, rdata, done, i == 0 ? 32'h0000_8001 : 32'hFFFF_8001); end
            tick();
        end
    endtask

    task automatic test_store_byte();
        set_req(0, 1, 2'b01, 0, 32'h201, 32'h0000_00AB);
        bus.mem_rdata = 32'h1122_3344; bus.mem_ack = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 30'h80}) begin errors++;
            $display("FAIL sb_read: got req=%b we=%b addr=%h want 1 0 80", bus.mem_req, bus.mem_we, bus.mem_addr); end
        tick();
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b11, 30'h80} || bus.mem_wdata !== 32'h1122_AB44) begin errors++;
            $display("FAIL sb_write: got req=%b we=%b addr=%h wdata=%h want 1 1 80 1122ab44", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({done, err, bus.mem_req} !== 3'b100) begin errors++; $display("FAIL sb_done: got done=%b err=%b req=%b want 1 0 0", done, err, bus.mem_req); end
        checks++; if (rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL sb_rdata_kept: got %h want ffff8001", rdata); end
        tick();
    endtask

    task automatic test_errors();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_req(0, 1, 2'b11, 0, 32'h006, 32'h5555_5555);
            else set_req(1, 1, 2'b11, 0, 32'h000, 0);
            tick();
            req_valid = 1'b0;
            checks++; if ({done, err, bus.mem_req} !== 3'b110 || rdata !== 32'h0) begin errors++;
                $display("FAIL err_%0d: got done=%b err=%b req=%b rdata=%h want 1 1 0 0", i, done, err, bus.mem_req, rdata); end
            tick();
            checks++; if ({ready, done, bus.mem_req} !== 3'b100) begin errors++; $display("FAIL err_%0d_idle: got ready=%b done=%b req=%b want 1 0 0", i, ready, done, bus.mem_req); end
        end
    endtask

    task automatic test_wait_states();
        set_req(0, 1, 2'b11, 0, 32'h010, 32'hDEAD_BEEF);
        bus.mem_ack = 1'b0;
        tick();
        set_req(1, 0, 2'b11, 0, 32'h040, 0);
        for (int c = 0; c < 5; c++) begin
            checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, ready} !== {2'b11, 30'h4, 32'hDEAD_BEEF, 2'b00}) begin errors++;
                $display("FAIL sw_wait_%0d: got req=%b we=%b addr=%h wdata=%h done=%b ready=%b want 1 1 4 deadbeef 0 0",
                         c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, ready); end
            tick();
        end
        bus.mem_ack = 1'b1; req_valid = 1'b0;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({done, err, bus.mem_req} !== 3'b100) begin errors++; $display("FAIL sw_done: got done=%b err=%b req=%b want 1 0 0", done, err, bus.mem_req); end
        tick();
        checks++; if ({ready, bus.mem_req} !== 2'b10) begin errors++; $display("FAIL sw_idle: got ready=%b req=%b want 1 0", ready, bus.mem_req); end
    endtask

    task automatic test_back_to_back();
        set_req(1, 0, 2'b11, 0, 32'h020, 0);
        bus.mem_rdata = 32'h1234_5678; bus.mem_ack = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || rdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_lw: got done=%b rdata=%h want 1 12345678", done, rdata); end
        set_req(1, 0, 2'b01, 0, 32'h021, 0);
        tick();
        checks++; if ({ready, bus.mem_req} !== 2'b10) begin errors++; $display("FAIL b2b_ready: got ready=%b req=%b want 1 0", ready, bus.mem_req); end
        tick();
        req_valid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h8) begin errors++; $display("FAIL b2b_accept: got req=%b addr=%h want 1 8", bus.mem_req, bus.mem_addr); end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (done !== 1'b1 || rdata !== 32'h0000_0056) begin errors++; $display("FAIL b2b_lbu: got done=%b rdata=%h want 1 00000056", done, rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        set_req(1, 0, 2'b11, 0, 32'h030, 0);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({ready, bus.mem_req} !== 2'b10) begin errors++; $display("FAIL rst_mid: got ready=%b req=%b want 1 0", ready, bus.mem_req); end
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.mem_ack = 1'b0;
            pulses += int'(done) + int'(bus.mem_req);
        end
        checks++; if (pulses !== 0 || ready !== 1'b1 || rdata !== 32'h0) begin errors++;
            $display("FAIL rst_late_ack: got done/req count=%0d ready=%b rdata=%h want 0 1 0", pulses, ready, rdata); end
        reset = 1'b1;
        set_req(1, 0, 2'b11, 0, 32'h030, 0);
        tick();
        reset = 1'b0; req_valid = 1'b0;
        tick();
        checks++; if ({ready, done, bus.mem_req} !== 3'b100) begin errors++; $display("FAIL rst_wins: got ready=%b done=%b req=%b want 1 0 0", ready, done, bus.mem_req); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_errors();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  CPU access request; accepted when req_valid && ready.
REQ-004 SHALL have: MemRead, MemWrite  in  1 each  access type from the control decoder.
REQ-005 SHALL have: MemDataSize  in  2  11=word, 10=halfword, 01=byte, 00=illegal.
REQ-006 SHALL have: MemDataSign  in  1  1=sign-extend loads, 0=zero-extend; ignored for stores.
REQ-007 SHALL have: addr  in  32  byte address; wdata  in  32  store data (low byte/half used for sub-word).
REQ-008 SHALL have: ready  out  1  high only in IDLE; rdata  out  32  load result; done  out  1  one-cycle completion pulse; err  out  1  valid with done.
REQ-009 SHALL have: mem_req  out  1, mem_we  out  1, mem_addr  out  30 (word address = addr[31:2]), mem_wdata  out  32, mem_rdata  in  32, mem_ack  in  1.
REQ-010 Reset SHALL be synchronous and active-high, on port reset, in the single clk domain.

Function
REQ-011 Byte order SHALL be little-endian: byte k of a word = bits [8k+7:8k], k=addr[1:0]; halfword h = bits [16h+15:16h], h=addr[1].
REQ-012 States SHALL be IDLE, READ, WRITE, DONE.
REQ-013 Request inputs SHALL be captured in IDLE on the edge where req_valid && ready; inputs are ignored at all other times.
REQ-014 Error check at acceptance: err SHALL be 1 for MemRead==MemWrite, MemDataSize==00, halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-015 On error, no memory transfer SHALL occur: IDLE->DONE, done=1, err=1, rdata=0 in the next cycle.
REQ-016 Load, or byte/half store, SHALL go IDLE->READ; word store SHALL go IDLE->WRITE.
REQ-017 mem_req SHALL be high exactly in READ and WRITE; mem_we=1 only in WRITE; mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack.
REQ-018 A transfer SHALL complete on each edge where mem_req && mem_ack; mem_ack with mem_req low SHALL be ignored; wait states are unbounded.
REQ-019 READ+ack for a load: extract the byte/half/word per REQ-011, extend per MemDataSign, latch into rdata, go to DONE.
REQ-020 READ+ack for a sub-word store: merge the low byte/half of wdata into mem_rdata at the addressed lane, leave other bytes unchanged, latch as mem_wdata, go to WRITE.
REQ-021 WRITE+ack SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-023 rdata SHALL hold its value until the next load completion or error; err is meaningful only while done=1.
REQ-024 Zero-wait latency (acceptance edge = cycle 0): load/word store done in cycle 2; sub-word store done in cycle 3; error done in cycle 1.
REQ-025 A back-to-back request SHALL be acceptable in the cycle after done, i.e. when ready is high again.
REQ-026 Stores SHALL never modify rdata.

Reset
REQ-027 Reset SHALL force IDLE, ready=1, done=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 on the next edge.
REQ-028 Reset mid-transfer SHALL abandon the access: mem_req low after the reset edge, no done pulse, and any late mem_ack SHALL be ignored.
REQ-029 Reset asserted together with req_valid SHALL win; the request is not accepted.

Verification
REQ-030 LB, addr=0x103, MemDataSign=1, mem_rdata=0x80FF_0000, ack in first cycle -> rdata=0xFFFF_FF80, done in cycle 2, err=0.
REQ-031 LHU, addr=0x102, mem_rdata=0x8001_1234 -> rdata=0x0000_8001; the same access with LH -> rdata=0xFFFF_8001.
REQ-032 SB, addr=0x201, wdata=0x0000_00AB, read returns 0x1122_3344 -> written word 0x1122_AB44, mem_addr=0x80 on both transfers, done in cycle 3.
REQ-033 SW, addr=0x006 -> no mem_req, done=1, err=1 in cycle 1; LW with MemRead=MemWrite=1 -> same response.
REQ-034 SW, addr=0x010, mem_ack withheld for 5 cycles -> mem_req/mem_we/mem_wdata stable throughout, done one cycle after ack, req_valid ignored while busy.
REQ-035 Reset asserted in READ while mem_ack is low, then mem_ack pulsed -> no done, ready=1, rdata unchanged at 0.
